// File: rtl/regex_cpu_buffered_pkg.sv
// Shared types for the buffered regex execution unit.
// Optional perf counters: define REGEX_CPU_PERF_COUNTERS_EN.
package regex_cpu_buffered_pkg;

  localparam int OPCODE_WIDTH = 3;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ACCEPT                = 3'd0,
    SPLIT                 = 3'd1,
    MATCH_CHAR            = 3'd2,
    JMP                   = 3'd3,
    END_WITHOUT_ACCEPTING = 3'd4,
    MATCH_ANY             = 3'd5,
    ACCEPT_PARTIAL        = 3'd6,
    NOT_MATCH             = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    EXEC,
    OUT,
    OUT2
  } state_e;

  function automatic int instr_data_width(int mem_w);
    return mem_w - OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/regex_cpu_buffered_if.sv
// Thread-in, thread-out and instruction-fetch handshakes.
// master = execution unit, slave = scheduler/memory side.
interface regex_cpu_buffered_if #(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic                         input_pc_valid;
  logic [CC_ID_BITS-1:0]        input_cc_id;
  logic [PC_WIDTH-1:0]          input_pc;
  logic                         input_pc_ready;
  logic                         memory_valid;
  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr;
  logic                         memory_ready;
  logic [MEMORY_WIDTH-1:0]      memory_data;
  logic                         output_pc_valid;
  logic [PC_WIDTH-1:0]          output_pc;
  logic [CC_ID_BITS-1:0]        output_cc_id;
  logic                         output_pc_ready;

  modport master (
    input  input_pc_valid, input_cc_id, input_pc,
    output input_pc_ready,
    output memory_valid, memory_addr,
    input  memory_ready, memory_data,
    output output_pc_valid, output_pc, output_cc_id,
    input  output_pc_ready
  );

  modport slave (
    output input_pc_valid, input_cc_id, input_pc,
    input  input_pc_ready,
    input  memory_valid, memory_addr,
    output memory_ready, memory_data,
    input  output_pc_valid, output_pc, output_cc_id,
    output output_pc_ready
  );
endinterface

// File: rtl/regex_cpu_pc_fifo.sv
// Input thread queue of {cc_id, pc} entries.
// Push is ignored when full, pop ignored when empty.
module regex_cpu_pc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wr_q, wr_d;
  logic [AW:0]             rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer and storage update
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_d = rd_q + (AW+1)'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end
endmodule

// File: rtl/regex_cpu_buffered.sv
// Regex execution unit with input thread FIFO.
// Optional perf counters: define REGEX_CPU_PERF_COUNTERS_EN.
module regex_cpu_buffered
  import regex_cpu_buffered_pkg::*;
#(
  parameter int PC_WIDTH          = 9,
  parameter int CC_ID_BITS        = 2,
  parameter int CHARACTER_WIDTH   = 8,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
  input  logic [(2**CC_ID_BITS)-1:0]                 end_of_string,
  regex_cpu_buffered_if.master                       bus,
  output logic                                       accepts
`ifdef REGEX_CPU_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_instr_count,
  output logic [31:0] perf_accept_count
`endif
);
  localparam int IDW = instr_data_width(MEMORY_WIDTH);
  localparam int TW  = CC_ID_BITS + PC_WIDTH;

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [CC_ID_BITS-1:0]   cc_q, cc_d;
  logic [MEMORY_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]     out_pc_q, out_pc_d;
  logic [CC_ID_BITS-1:0]   out_cc_q, out_cc_d;
  logic                    acc_q, acc_d;
  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [TW-1:0]           fifo_head;
  logic                    exec_fire;

  opcode_e                  op;
  logic [IDW-1:0]           data;
  logic [CHARACTER_WIDTH-1:0] ch;
  logic                     eos;
  logic [PC_WIDTH-1:0]      pc_inc, tgt;
  logic [CC_ID_BITS-1:0]    cc_inc;

  assign op     = opcode_e'(instr_q[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
  assign data   = instr_q[IDW-1:0];
  assign tgt    = data[PC_WIDTH-1:0];
  assign ch     = current_characters[cc_q*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign eos    = end_of_string[cc_q];
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign cc_inc = cc_q + CC_ID_BITS'(1);

  regex_cpu_pc_fifo #(.DEPTH(FIFO_DEPTH), .W(TW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.input_pc_valid),
    .push_data ({bus.input_cc_id, bus.input_pc}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.input_pc_ready  = !fifo_full;
  assign bus.memory_valid    = (state_q == FETCH);
  assign bus.memory_addr     = MEMORY_ADDR_WIDTH'(pc_q);
  assign bus.output_pc_valid = (state_q == OUT) || (state_q == OUT2);
  assign bus.output_pc       = out_pc_q;
  assign bus.output_cc_id    = out_cc_q;
  assign accepts             = acc_q;

  // Thread sequencing: pop, fetch, execute, emit successors
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cc_d      = cc_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    out_cc_d  = out_cc_q;
    acc_d     = 1'b0;
    fifo_pop  = 1'b0;
    exec_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pc_d     = fifo_head[PC_WIDTH-1:0];
          cc_d     = fifo_head[TW-1:PC_WIDTH];
          state_d  = FETCH;
        end
      end
      FETCH: if (bus.memory_ready) state_d = DATA;
      DATA: begin
        instr_d = bus.memory_data;
        state_d = EXEC;
      end
      EXEC: begin
        exec_fire = 1'b1;
        state_d   = IDLE;
        out_cc_d  = cc_q;
        unique case (op)
          JMP: begin
            out_pc_d = tgt;
            state_d  = OUT;
          end
          SPLIT: begin
            out_pc_d = pc_inc;
            state_d  = OUT;
          end
          MATCH_CHAR, NOT_MATCH, MATCH_ANY: begin
            if (!eos &&
                (op == MATCH_ANY ||
                 ((ch == data[CHARACTER_WIDTH-1:0]) == (op == MATCH_CHAR)))) begin
              out_pc_d = pc_inc;
              out_cc_d = cc_inc;
              state_d  = OUT;
            end
          end
          ACCEPT:         acc_d = eos;
          ACCEPT_PARTIAL: acc_d = 1'b1;
          default: ;
        endcase
      end
      OUT: begin
        if (bus.output_pc_ready) begin
          if (op == SPLIT) begin
            out_pc_d = tgt;
            state_d  = OUT2;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OUT2: if (bus.output_pc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Execution state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cc_q     <= '0;
      instr_q  <= '0;
      out_pc_q <= '0;
      out_cc_q <= '0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cc_q     <= cc_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      out_cc_q <= out_cc_d;
      acc_q    <= acc_d;
    end
  end

`ifdef REGEX_CPU_PERF_COUNTERS_EN
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] acnt_q, acnt_d;

  // Saturating instruction and accept counters
  always_comb begin
    icnt_d = icnt_q;
    acnt_d = acnt_q;
    if (exec_fire && icnt_q != '1) icnt_d = icnt_q + 32'd1;
    if (acc_q && acnt_q != '1)     acnt_d = acnt_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt_q <= '0;
      acnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      acnt_q <= acnt_d;
    end
  end

  assign perf_instr_count  = icnt_q;
  assign perf_accept_count = acnt_q;
`endif
endmodule

// File: tb/tb_regex_cpu_buffered.sv
// Directed bench for regex_cpu_buffered.
// Optional perf counters: define REGEX_CPU_PERF_COUNTERS_EN.
module tb_regex_cpu_buffered;
  localparam logic [2:0] O_ACCEPT = 3'd0;
  localparam logic [2:0] O_SPLIT  = 3'd1;
  localparam logic [2:0] O_MC     = 3'd2;
  localparam logic [2:0] O_JMP    = 3'd3;
  localparam logic [2:0] O_END    = 3'd4;
  localparam logic [2:0] O_ANY    = 3'd5;
  localparam logic [2:0] O_AP     = 3'd6;
  localparam logic [2:0] O_NM     = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] chars;
  logic [3:0]  eos;
  logic        accepts;
  int          checks = 0;
  int          failures = 0;
`ifdef REGEX_CPU_PERF_COUNTERS_EN
  logic [31:0] perf_instr_count;
  logic [31:0] perf_accept_count;
`endif

  regex_cpu_buffered_if #(
    .PC_WIDTH(9), .CC_ID_BITS(2),
    .MEMORY_WIDTH(16), .MEMORY_ADDR_WIDTH(11)
  ) bus ();

  regex_cpu_buffered dut (
    .clk                (clk),
    .rst                (rst),
    .current_characters (chars),
    .end_of_string      (eos),
    .bus                (bus),
    .accepts            (accepts)
`ifdef REGEX_CPU_PERF_COUNTERS_EN
    ,
    .perf_instr_count   (perf_instr_count),
    .perf_accept_count  (perf_accept_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] w(logic [2:0] op, logic [12:0] d);
    return {op, d};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(logic [8:0] pc, logic [1:0] cc);
    @(negedge clk);
    bus.input_pc_valid = 1'b1;
    bus.input_pc       = pc;
    bus.input_cc_id    = cc;
    @(negedge clk);
    bus.input_pc_valid = 1'b0;
  endtask

  // serve one fetch; returns at the negedge after EXEC
  task automatic serve(string tag, logic [10:0] addr, logic [15:0] word);
    int n = 0;
    while (bus.memory_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_fetch"}, 32'(bus.memory_valid), 32'd1);
    chk({tag, "_addr"}, 32'(bus.memory_addr), 32'(addr));
    bus.memory_ready = 1'b1;
    @(negedge clk);
    bus.memory_ready = 1'b0;
    bus.memory_data  = word;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic take(string tag, logic [8:0] pc, logic [1:0] cc);
    chk({tag, "_valid"}, 32'(bus.output_pc_valid), 32'd1);
    chk({tag, "_pc"}, 32'(bus.output_pc), 32'(pc));
    chk({tag, "_cc"}, 32'(bus.output_cc_id), 32'(cc));
    bus.output_pc_ready = 1'b1;
    @(negedge clk);
    bus.output_pc_ready = 1'b0;
  endtask

  task automatic quiet(string tag, int n);
    logic bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.output_pc_valid !== 1'b0 || bus.memory_valid !== 1'b0)
        bad = 1'b1;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  logic [8:0]  jpc [4] = '{9'd0, 9'd1, 9'd255, 9'd510};
  logic [12:0] jdat[4] = '{13'd98, 13'd150, 13'd200, 13'd304};

  initial begin
    bus.input_pc_valid  = 1'b0;
    bus.input_pc        = '0;
    bus.input_cc_id     = '0;
    bus.memory_ready    = 1'b0;
    bus.memory_data     = '0;
    bus.output_pc_ready = 1'b0;
    chars = '0;
    eos   = '0;

    #12;
    chk("rst_mem_valid", 32'(bus.memory_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.output_pc_valid), 32'd0);
    chk("rst_accepts", 32'(accepts), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.input_pc_ready), 32'd1);

    push(9'd0, 2'd0);
    chk("lat_idle", 32'(bus.memory_valid), 32'd0);
    @(negedge clk);
    chk("lat_fetch", 32'(bus.memory_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) push(jpc[i], 2'(i));
      serve("jmp", 11'(jpc[i]), w(O_JMP, jdat[i]));
      take("jmp", 9'(jdat[i]), 2'(i));
      quiet("jmp_quiet", 10);
    end

    push(9'd3, 2'd0);
    serve("jmp_trunc", 11'd3, w(O_JMP, 13'd5000));
    take("jmp_trunc", 9'd392, 2'd0);

    push(9'd7, 2'd2);
    serve("split", 11'd7, w(O_SPLIT, 13'd40));
    repeat (5) begin
      chk("split_hold_pc", 32'(bus.output_pc), 32'd8);
      chk("split_hold_v", 32'(bus.output_pc_valid), 32'd1);
      @(negedge clk);
    end
    take("split_a", 9'd8, 2'd2);
    take("split_b", 9'd40, 2'd2);
    chk("split_done", 32'(bus.output_pc_valid), 32'd0);

    chars = 32'h6100_0000;
    push(9'd511, 2'd3);
    serve("mc_hit", 11'd511, w(O_MC, 13'h61));
    take("mc_hit", 9'd0, 2'd0);
    chars = 32'h6200_0000;
    push(9'd511, 2'd3);
    serve("mc_miss", 11'd511, w(O_MC, 13'h61));
    chk("mc_miss_drop", 32'(bus.output_pc_valid), 32'd0);
    chars = 32'h6100_0000;
    eos   = 4'b1000;
    push(9'd511, 2'd3);
    serve("mc_eos", 11'd511, w(O_MC, 13'h61));
    chk("mc_eos_drop", 32'(bus.output_pc_valid), 32'd0);
    eos = 4'b0000;

    chars = 32'h0000_0079;
    push(9'd10, 2'd0);
    serve("nm_hit", 11'd10, w(O_NM, 13'h78));
    take("nm_hit", 9'd11, 2'd1);
    push(9'd10, 2'd0);
    serve("nm_eq", 11'd10, w(O_NM, 13'h79));
    chk("nm_eq_drop", 32'(bus.output_pc_valid), 32'd0);

    eos = 4'b0010;
    push(9'd20, 2'd1);
    serve("any_eos", 11'd20, w(O_ANY, 13'd0));
    chk("any_eos_drop", 32'(bus.output_pc_valid), 32'd0);
    eos = 4'b0000;
    push(9'd20, 2'd1);
    serve("any", 11'd20, w(O_ANY, 13'd0));
    take("any", 9'd21, 2'd2);

    eos = 4'b0010;
    push(9'd30, 2'd1);
    serve("acc", 11'd30, w(O_ACCEPT, 13'd0));
    chk("acc_pulse", 32'(accepts), 32'd1);
    chk("acc_no_out", 32'(bus.output_pc_valid), 32'd0);
    @(negedge clk);
    chk("acc_single", 32'(accepts), 32'd0);
    eos = 4'b0000;
    push(9'd30, 2'd1);
    serve("acc_noeos", 11'd30, w(O_ACCEPT, 13'd0));
    chk("acc_noeos", 32'(accepts), 32'd0);
    push(9'd31, 2'd1);
    serve("accp", 11'd31, w(O_AP, 13'd0));
    chk("accp_pulse", 32'(accepts), 32'd1);
    @(negedge clk);
    chk("accp_single", 32'(accepts), 32'd0);
    push(9'd32, 2'd0);
    serve("end", 11'd32, w(O_END, 13'd0));
    chk("end_drop", 32'(bus.output_pc_valid), 32'd0);
    chk("end_no_acc", 32'(accepts), 32'd0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fifo_rdy", 32'(bus.input_pc_ready), 32'd1);
      bus.input_pc_valid = 1'b1;
      bus.input_pc       = 9'(100 + i);
      bus.input_cc_id    = 2'(i);
    end
    @(negedge clk);
    bus.input_pc_valid = 1'b0;
    chk("fifo_full", 32'(bus.input_pc_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      serve("fifo", 11'(100 + i), w(O_JMP, 13'(300 + i)));
      take("fifo", 9'(300 + i), 2'(i));
    end
    chk("fifo_drain_rdy", 32'(bus.input_pc_ready), 32'd1);

    push(9'd60, 2'd2);
    serve("rst_op", 11'd60, w(O_JMP, 13'd70));
    chk("rst_op_valid", 32'(bus.output_pc_valid), 32'd1);
    bus.input_pc_valid = 1'b1;
    bus.input_pc       = 9'd61;
    bus.input_cc_id    = 2'd1;
    @(negedge clk);
    bus.input_pc_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out", 32'(bus.output_pc_valid), 32'd0);
    chk("midrst_mem", 32'(bus.memory_valid), 32'd0);
    chk("midrst_acc", 32'(accepts), 32'd0);
    chk("midrst_rdy", 32'(bus.input_pc_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    quiet("midrst_empty", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
